// File: rtl/mat_result_streamer_pkg.sv
// Shared constants and FSM encoding for the matrix core and its result streamer.
package mat_result_streamer_pkg;
    localparam int MAX_SIZE     = 13;
    localparam int DATA_BW      = 16;
    localparam int SQU_MAX_SIZE = MAX_SIZE * MAX_SIZE;
    localparam int ACC_BW       = 2 * DATA_BW;
    localparam int OUT_BW       = 16;
    localparam int IDX_BW       = $clog2(SQU_MAX_SIZE);
    localparam int COL_BW       = $clog2(MAX_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/mat_result_streamer_if.sv
// Valid/ready element stream from the result streamer toward writeback/DMA.
interface mat_result_streamer_if #(
    parameter int OUT_BW = 16
);
    logic              m_valid;
    logic              m_ready;
    logic [OUT_BW-1:0] m_data;
    logic              m_row_last;
    logic              m_last;

    modport master (output m_valid, m_data, m_row_last, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_row_last, m_last, output m_ready);
endinterface

// File: rtl/mat_result_streamer_requant.sv
// Requantise one unsigned accumulator: round-half-up right shift, then saturate to OUT_BW.
module mat_requant_sat
    import mat_result_streamer_pkg::*;
(
    input  logic [ACC_BW-1:0] i_x,
    input  logic [4:0]        i_shift,
    output logic [OUT_BW-1:0] o_data,
    output logic              o_sat
);
    logic [ACC_BW:0] w_round;
    logic [ACC_BW:0] w_sum;
    logic [ACC_BW:0] w_shifted;

    // One extra bit keeps the rounding carry of an all-ones accumulator.
    assign w_round   = (i_shift == 5'd0) ? '0 : ((ACC_BW+1)'(1) << (i_shift - 5'd1));
    assign w_sum     = {1'b0, i_x} + w_round;
    assign w_shifted = w_sum >> i_shift;
    assign o_sat     = |w_shifted[ACC_BW:OUT_BW];
    assign o_data    = o_sat ? '1 : w_shifted[OUT_BW-1:0];
endmodule

// File: rtl/mat_result_streamer.sv
// Captures the core's flat result on the finish edge and streams requantised elements row-major.
module mat_result_streamer
    import mat_result_streamer_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           finish,
    input  logic [SQU_MAX_SIZE*ACC_BW-1:0] data_in,
    input  logic [4:0]                     shift,
    mat_result_streamer_if.master          m_if,
    output logic                           busy,
    output logic                           done,
    output logic                           sat_flag
);
    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(SQU_MAX_SIZE - 1);
    localparam logic [COL_BW-1:0] LAST_COL = COL_BW'(MAX_SIZE - 1);

    state_t              r_state, w_state_next;
    logic                r_finish_d;
    logic [ACC_BW-1:0]   r_buf  [SQU_MAX_SIZE];
    logic [ACC_BW-1:0]   w_elem [SQU_MAX_SIZE];
    logic [4:0]          r_shift;
    logic [IDX_BW-1:0]   r_index, w_index_next, w_rd_idx;
    logic [COL_BW-1:0]   r_col, w_col_next;
    logic [COL_BW-1:0]   r_row, w_row_next;
    logic [OUT_BW-1:0]   r_data;
    logic                r_row_last, r_last, r_sat_elem, r_sat_flag;
    logic                w_trigger, w_handshake, w_load_first, w_advance;
    logic [ACC_BW-1:0]   w_rq_x;
    logic [4:0]          w_rq_shift;
    logic [OUT_BW-1:0]   w_rq_data;
    logic                w_rq_sat;

    genvar gi;
    generate
        for (gi = 0; gi < SQU_MAX_SIZE; gi++) begin : g_elem
            assign w_elem[gi] = data_in[gi*ACC_BW +: ACC_BW];
        end
    endgenerate

    assign w_trigger   = finish & ~r_finish_d;
    assign w_handshake = (r_state == ST_STREAM) & m_if.m_ready;

    always_comb begin
        w_state_next = r_state;
        w_load_first = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_next = ST_STREAM;
                    w_load_first = 1'b1;
                end
            end
            ST_STREAM: begin
                if (w_handshake) begin
                    if (r_index == LAST_IDX) w_state_next = ST_DONE;
                    else                     w_advance    = 1'b1;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_index_next = r_index + IDX_BW'(1);
    assign w_col_next   = (r_col == LAST_COL) ? '0 : r_col + COL_BW'(1);
    assign w_row_next   = (r_col == LAST_COL) ? r_row + COL_BW'(1) : r_row;
    assign w_rd_idx     = (r_index == LAST_IDX) ? '0 : w_index_next;

    // The first element bypasses the buffer so it is valid the cycle after capture.
    assign w_rq_x     = w_load_first ? w_elem[0] : r_buf[w_rd_idx];
    assign w_rq_shift = w_load_first ? shift : r_shift;

    mat_requant_sat u_requant (
        .i_x     (w_rq_x),
        .i_shift (w_rq_shift),
        .o_data  (w_rq_data),
        .o_sat   (w_rq_sat)
    );

    always_ff @(posedge clk) begin
        if (w_load_first) begin
            for (int i = 0; i < SQU_MAX_SIZE; i++) r_buf[i] <= w_elem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_finish_d <= 1'b0;
            r_shift    <= '0;
            r_index    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_data     <= '0;
            r_row_last <= 1'b0;
            r_last     <= 1'b0;
            r_sat_elem <= 1'b0;
            r_sat_flag <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_finish_d <= finish;
            if (w_load_first) begin
                r_shift    <= shift;
                r_index    <= '0;
                r_col      <= '0;
                r_row      <= '0;
                r_data     <= w_rq_data;
                r_sat_elem <= w_rq_sat;
                r_row_last <= (MAX_SIZE == 1);
                r_last     <= (SQU_MAX_SIZE == 1);
                r_sat_flag <= 1'b0;
            end else if (w_advance) begin
                r_index    <= w_index_next;
                r_col      <= w_col_next;
                r_row      <= w_row_next;
                r_data     <= w_rq_data;
                r_sat_elem <= w_rq_sat;
                r_row_last <= (w_col_next == LAST_COL);
                r_last     <= (w_index_next == LAST_IDX);
            end
            if (w_handshake) r_sat_flag <= r_sat_flag | r_sat_elem;
        end
    end

    assign m_if.m_valid    = (r_state == ST_STREAM);
    assign m_if.m_data     = r_data;
    assign m_if.m_row_last = r_row_last;
    assign m_if.m_last     = r_last;
    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_DONE);
    assign sat_flag        = r_sat_flag;
endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed + randomized bench for mat_result_streamer against an arithmetic reference model.
module tb_mat_result_streamer;
    import mat_result_streamer_pkg::*;

    logic                           clk;
    logic                           rst;
    logic                           finish;
    logic [SQU_MAX_SIZE*ACC_BW-1:0] data_in;
    logic [4:0]                     shift;
    logic                           busy, done, sat_flag;

    mat_result_streamer_if #(.OUT_BW(OUT_BW)) s_if ();

    mat_result_streamer dut (
        .clk      (clk),
        .rst      (rst),
        .finish   (finish),
        .data_in  (data_in),
        .shift    (shift),
        .m_if     (s_if.master),
        .busy     (busy),
        .done     (done),
        .sat_flag (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int unsigned mdl   [SQU_MAX_SIZE];
    int unsigned exp_d [SQU_MAX_SIZE];
    bit          exp_s [SQU_MAX_SIZE];
    int unsigned got_d [SQU_MAX_SIZE];
    bit          frame_sat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint unsigned ref_r(input int unsigned x, input int sh);
        longint unsigned half;
        half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
        return (longint'(x) + half) / (64'd1 << sh);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data(input int sh);
        for (int i = 0; i < SQU_MAX_SIZE; i++) data_in[i*ACC_BW +: ACC_BW] = mdl[i];
        shift = sh[4:0];
        frame_sat = 1'b0;
        for (int i = 0; i < SQU_MAX_SIZE; i++) begin
            longint unsigned r;
            r = ref_r(mdl[i], sh);
            exp_s[i] = (r > 64'd65535);
            exp_d[i] = exp_s[i] ? 32'hFFFF : int'(r);
            frame_sat |= exp_s[i];
        end
    endtask

    task automatic random_data();
        for (int i = 0; i < SQU_MAX_SIZE; i++) mdl[i] = $urandom >> $urandom_range(0, 31);
    endtask

    // Caller guarantees finish was low at the previous edge.
    task automatic start_frame();
        finish = 1'b1;
        tick();
        chk("first_valid", s_if.m_valid, 1);
    endtask

    task automatic idle_gap();
        finish = 1'b0;
        tick();
    endtask

    task automatic stream(input int mode, input int abort_at, input int glitch_at, output int cycles);
        int k;
        bit prev_stall, sat_acc, rdy;
        logic [OUT_BW-1:0] prev_d;
        k = 0; prev_stall = 0; sat_acc = 0; cycles = 0; prev_d = '0;
        while (k < SQU_MAX_SIZE && k < abort_at && cycles < 3000) begin
            chk("valid_in_stream", s_if.m_valid, 1);
            chk("busy_in_stream", busy, 1);
            chk("sat_running", sat_flag, sat_acc);
            if (prev_stall) chk("stall_hold", s_if.m_data, prev_d);
            rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0 ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_if.m_ready = rdy;
            if (cycles == glitch_at) begin
                finish = 1'b0;
                for (int i = 0; i < SQU_MAX_SIZE; i++) data_in[i*ACC_BW +: ACC_BW] = $urandom;
            end
            if (cycles == glitch_at + 1) finish = 1'b1;
            if (rdy) begin
                chk("beat_data", s_if.m_data, exp_d[k]);
                chk("beat_row_last", s_if.m_row_last, (k % MAX_SIZE) == MAX_SIZE - 1);
                chk("beat_last", s_if.m_last, k == SQU_MAX_SIZE - 1);
                got_d[k] = s_if.m_data;
                if (exp_s[k]) sat_acc = 1'b1;
                k++;
            end else begin
                prev_d = s_if.m_data;
            end
            prev_stall = !rdy;
            tick();
            cycles++;
        end
        if (abort_at >= SQU_MAX_SIZE) begin
            chk("beats_total", k, SQU_MAX_SIZE);
            chk("done_pulse", done, 1);
            chk("done_valid_low", s_if.m_valid, 0);
            chk("done_busy", busy, 1);
            chk("sat_frame", sat_flag, frame_sat);
            tick();
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_valid", s_if.m_valid, 0);
            chk("sat_hold", sat_flag, frame_sat);
        end else begin
            chk("beats_before_abort", k, abort_at);
        end
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("no_retrigger_busy", busy, 0);
            chk("no_retrigger_valid", s_if.m_valid, 0);
            tick();
        end
    endtask

    task automatic check_reset_state();
        chk("rst_valid", s_if.m_valid, 0);
        chk("rst_data", s_if.m_data, 0);
        chk("rst_row_last", s_if.m_row_last, 0);
        chk("rst_last", s_if.m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat_flag, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; finish = 1'b0; data_in = '0; shift = '0; s_if.m_ready = 1'b0;
        repeat (3) tick();
        check_reset_state();
        rst = 1'b0;
        tick();

        // Identity frame, full throughput; finish then stays high.
        for (int i = 0; i < SQU_MAX_SIZE; i++) mdl[i] = i;
        load_data(0);
        start_frame();
        stream(0, SQU_MAX_SIZE, -1, cyc);
        chk("identity_cycles", cyc, SQU_MAX_SIZE);
        chk("identity_no_sat", sat_flag, 0);
        expect_idle(5);
        idle_gap();

        // Rounding and saturation corner values.
        random_data(); mdl[0] = 32'h6;
        load_data(2); start_frame(); stream(1, SQU_MAX_SIZE, -1, cyc);
        chk("round_6_s2", got_d[0], 2);
        idle_gap();
        random_data(); mdl[0] = 32'h5; mdl[1] = 32'h0001_FFFF;
        load_data(1); start_frame(); stream(1, SQU_MAX_SIZE, -1, cyc);
        chk("round_5_s1", got_d[0], 3);
        chk("sat_1ffff_s1", got_d[1], 16'hFFFF);
        chk("sat_flag_s1", sat_flag, 1);
        idle_gap();
        random_data(); mdl[0] = 32'h4; mdl[1] = 32'h3;
        load_data(3); start_frame(); stream(1, SQU_MAX_SIZE, -1, cyc);
        chk("round_4_s3", got_d[0], 1);
        chk("round_3_s3", got_d[1], 0);
        idle_gap();
        random_data(); mdl[0] = 32'h0001_0000;
        load_data(0); start_frame(); stream(0, SQU_MAX_SIZE, -1, cyc);
        chk("sat_10000_s0", got_d[0], 16'hFFFF);
        chk("sat_flag_s0", sat_flag, 1);
        idle_gap();

        // Backpressure with random data and shift.
        for (int f = 0; f < 3; f++) begin
            random_data();
            load_data($urandom_range(0, 31));
            start_frame();
            stream(1, SQU_MAX_SIZE, -1, cyc);
            idle_gap();
        end

        // Reset mid-frame, then a fresh frame with new data.
        random_data(); load_data($urandom_range(0, 8));
        start_frame();
        stream(0, 50, -1, cyc);
        rst = 1'b1; finish = 1'b0;
        tick();
        check_reset_state();
        tick();
        rst = 1'b0;
        tick();
        random_data(); load_data($urandom_range(0, 8));
        start_frame();
        stream(1, SQU_MAX_SIZE, -1, cyc);
        idle_gap();

        // Finish edge during STREAM is ignored; held finish after DONE gives no frame.
        random_data(); load_data($urandom_range(0, 31));
        start_frame();
        stream(1, SQU_MAX_SIZE, 20, cyc);
        expect_idle(4);
        idle_gap();
        random_data(); load_data($urandom_range(0, 31));
        start_frame();
        stream(0, SQU_MAX_SIZE, -1, cyc);
        idle_gap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
